ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Parametrised multi-cycle RV32M execute unit that sits beside the single-cycle ALU in the EX stage. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively and applies the same three-way operand forwarding as the EX stage. It holds the front of the pipeline with `stall` until the result is ready, then presents the result for one cycle so the EX/MEM register captures it in place of the ALU output.

## Interface
- `XLEN`, default 32: operand and result width, even, ≥ 8.
- `clk`  in  1: pipeline clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: ID/EX holds a valid M-extension op; held high while stalled.
- `funct3`  in  3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`, `rs2_val`  in  XLEN: register-file operands from ID/EX.
- `forwardA`, `forwardB`  in  2: 00 ID/EX value, 10 `ex_mem_alu_out`, 01 `mem_wb_wdata`, 11 ID/EX value.
- `ex_mem_alu_out`, `mem_wb_wdata`  in  XLEN: forwarding sources.
- `flush`  in  1: kill the in-flight op (branch redirect / exception).
- `stall`  out  1: hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- `busy`  out  1: state ≠ IDLE.
- `result_valid`  out  1: result is valid this cycle; single-cycle pulse.
- `result`  out  XLEN: M-extension result.

## Operation
- FSM states:
  - **IDLE**: waiting.
  - **BUSY**: iterating; a counter of width clog2(XLEN+1) counts XLEN steps.
  - **DONE**: result presented.
- **IDLE, `start`=1, no flush**:
  - Latch the forwarded operands A/B and `funct3`; the forwarding mux is evaluated only in this cycle.
  - Later changes on the forwarding sources or `rs*_val` have no effect.
- **Special cases, detected in IDLE**: go straight to DONE with no iteration.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (dividend = −2^(XLEN−1), divisor = −1): DIV gives −2^(XLEN−1); REM gives 0.
- **Multiply**:
  - Radix-2 shift-add on the unsigned magnitudes into a 2·XLEN accumulator, one bit per cycle.
  - Operand signedness: MUL and MULH treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU treats both as unsigned.
  - Product sign = sign(A) XOR sign(B), restricted to the signed operands; the 2·XLEN product is negated in DONE when the sign is negative.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- **Divide**:
  - Restoring division on magnitudes, one quotient bit per cycle, XLEN cycles.
  - Quotient sign = sign(A) XOR sign(B); remainder takes the sign of the dividend. Both are applied for DIV/REM only.
- **BUSY → DONE**: after the XLEN-th step.
- **DONE → IDLE** unconditionally, so a new op is accepted no earlier than the following cycle.
- **`flush`** in any state:
  - Next state is IDLE.
  - `result_valid` is forced 0 in the flush cycle.
  - `stall` is forced 0 in the flush cycle.
  - A `start` coincident with `flush` is ignored.
- **`stall`** = !`flush` && ((IDLE && `start`) || BUSY).
  - `stall` is 0 in DONE so the pipeline advances on the DONE edge.
- **`result`**:
  - Registered; updated only when entering DONE.
  - Holds its last value otherwise.
  - Must only be consumed when `result_valid`=1.

## Timing
- **Reset** (asynchronous, while `rst_n`=0):
  - State IDLE, counter 0, accumulators 0.
  - `result` = 0, `result_valid` = 0, `busy` = 0.
  - `stall` = 0 while `rst_n`=0, regardless of `start`.
- **Normal op**:
  - `start` sampled at edge 0.
  - BUSY for cycles 1..XLEN.
  - DONE at cycle XLEN+1.
  - Total latency XLEN+1 cycles; `stall` high for XLEN+1 cycles (cycles 0..XLEN).
- **Special case**:
  - IDLE at cycle 0, DONE at cycle 1.
  - Latency 1; `stall` high for exactly 1 cycle.
- **`result_valid`**: high exactly in the DONE cycle; never high two consecutive cycles.
- **Back-to-back M ops**: the second `start` is seen in the cycle after DONE (IDLE); no lost or duplicated result.
- **Reset asserted mid-BUSY**: outputs go to reset values immediately; no `result_valid` follows reset release.

## Test plan
- MUL −3 × 7 (XLEN=32) → `result`=0xFFFFFFEB, `result_valid` at cycle 33, `stall` high cycles 0–32; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −20 / 6 → 0xFFFFFFFD; REM −20 / 6 → 0xFFFFFFFE; DIVU 100 / 7 → 14, REMU → 2; each with 33-cycle latency.
- Special cases, each with `result_valid` at cycle 1 and `stall` high for exactly 1 cycle:
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Forwarding: `forwardA`=10, `ex_mem_alu_out`=100, `forwardB`=01, `mem_wb_wdata`=7, DIV. Change both sources to 0 during BUSY → `result`=14.
- `flush` at BUSY cycle 10 → IDLE next edge, `stall`=0 that cycle, no `result_valid`. A subsequent MUL 6×7 → 42.
- `rst_n` pulled low at BUSY cycle 5 → `busy`/`stall`/`result_valid`/`result` = 0 immediately. After release, idle with no pulse. Back-to-back DIVU 9/3 then MUL 3×3 → two single-cycle `result_valid` pulses with values 3 and 9.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, funct3                 valid M op in ID/EX and its operation select
//   rs1_val, rs2_val              register-file operands from ID/EX
//   forwardA, forwardB            operand source select (10 EX/MEM, 01 MEM/WB, else ID/EX)
//   ex_mem_alu_out, mem_wb_wdata  forwarding sources
//   flush                         kill the in-flight op
//   stall                         hold the pipeline front while the op is in progress
//   busy                          unit not idle
//   result_valid, result          one-cycle result presentation
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] ex_mem_alu_out,
    input  logic [XLEN-1:0] mem_wb_wdata,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   oper;      // multiplicand magnitude or divisor magnitude
    logic [2*XLEN-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic              neg_q;     // product / quotient must be negated
    logic              neg_r;     // remainder must be negated

    // Operand capture path, only meaningful in the accepting IDLE cycle
    logic [XLEN-1:0] op_a, op_b, a_abs, b_abs, special_res;
    logic            is_div_in, a_signed_in, b_signed_in, a_sgn, b_sgn;
    logic            div_zero, div_ovf, special;

    always_comb begin
        case (forwardA)
            2'b10:   op_a = ex_mem_alu_out;
            2'b01:   op_a = mem_wb_wdata;
            default: op_a = rs1_val;
        endcase
        case (forwardB)
            2'b10:   op_b = ex_mem_alu_out;
            2'b01:   op_b = mem_wb_wdata;
            default: op_b = rs2_val;
        endcase
        is_div_in   = funct3[2];
        // Divide: funct3[0]=0 is signed. Multiply: only MULHU has unsigned A,
        // only MUL/MULH have signed B.
        a_signed_in = is_div_in ? ~funct3[0] : (funct3 != 3'b011);
        b_signed_in = is_div_in ? ~funct3[0] : ~funct3[1];
        a_sgn       = a_signed_in & op_a[XLEN-1];
        b_sgn       = b_signed_in & op_b[XLEN-1];
        a_abs       = a_sgn ? -op_a : op_a;
        b_abs       = b_sgn ? -op_b : op_b;
        div_zero    = is_div_in && (op_b == '0);
        div_ovf     = is_div_in && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special     = div_zero || div_ovf;
        if (div_zero) special_res = funct3[1] ? op_a : '1;
        else          special_res = funct3[1] ? '0 : op_a;
    end

    // One iteration step and the final sign fix-up
    logic [XLEN:0]     mul_sum, div_cand, div_diff;
    logic [2*XLEN-1:0] acc_nxt, prod;
    logic [XLEN-1:0]   quo, rem, final_res;
    logic              last_step;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? oper : {XLEN{1'b0}})};
        div_cand = acc[2*XLEN-1:XLEN-1];
        div_diff = div_cand - {1'b0, oper};
        if (!op[2])
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_nxt = {div_cand[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod = neg_q ? -acc_nxt : acc_nxt;
        quo  = acc_nxt[XLEN-1:0];
        rem  = acc_nxt[2*XLEN-1:XLEN];
        if (!op[2])
            final_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (op[1])
            final_res = neg_r ? -rem : rem;
        else
            final_res = neg_q ? -quo : quo;
        last_step = (state == S_BUSY) && (cnt == CW'(XLEN - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        result_valid = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                stall     = 1'b1;
                state_nxt = special ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                stall = 1'b1;
                if (last_step) state_nxt = S_DONE;
            end
            S_DONE: begin
                result_valid = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt    = S_IDLE;
            stall        = 1'b0;
            result_valid = 1'b0;
        end
        // start may be high while reset is held; the pipeline must not be frozen
        if (!rst_n) stall = 1'b0;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op     <= '0;
            oper   <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: if (start) begin
                    op    <= funct3;
                    neg_q <= a_sgn ^ b_sgn;
                    neg_r <= a_sgn;
                    cnt   <= '0;
                    if (is_div_in) begin
                        acc  <= {{XLEN{1'b0}}, a_abs};
                        oper <= b_abs;
                    end else begin
                        acc  <= {{XLEN{1'b0}}, b_abs};
                        oper <= a_abs;
                    end
                    if (special) result <= special_res;
                end
                S_BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (last_step) result <= final_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_val = '0, rs2_val = '0, ex_mem_alu_out = '0, mem_wb_wdata = '0;
    logic [1:0]  forwardA = 2'b00, forwardB = 2'b00;
    logic        stall, busy, result_valid;
    logic [31:0] result;

    ex_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .forwardA(forwardA), .forwardB(forwardB),
        .ex_mem_alu_out(ex_mem_alu_out), .mem_wb_wdata(mem_wb_wdata),
        .flush(flush), .stall(stall), .busy(busy),
        .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Reference timeline of the op in flight
    bit          op_active = 0;
    int          op_c0 = 0, op_lat = 0, n_valid = 0;
    logic [31:0] op_exp = '0, last_result = '0, cap_val = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // RV32M semantics computed with plain wide arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] xa, xb, p;
        int sa, sb;
        sa = a;
        sb = b;
        if (!f[2]) begin
            xa = (f != 3'b011 && a[31]) ? {{34{1'b1}}, a} : {34'b0, a};
            xb = (!f[1] && b[31])       ? {{34{1'b1}}, b} : {34'b0, b};
            p  = xa * xb;
            return (f == 3'b000) ? p[31:0] : p[63:32];
        end
        case (f)
            3'b100:  if (b == 0) return 32'hFFFFFFFF;
                     else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                     else return sa / sb;
            3'b101:  return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110:  if (b == 0) return a;
                     else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                     else return sa % sb;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return XLEN + 1;
    endfunction

    // Compare process: every cycle, outputs against the reference timeline
    always @(negedge clk) begin : compare
        int rel;
        bit es, ev, eb;
        if (!rst_n) begin
            op_active   = 0;
            last_result = '0;
            chk("rst_stall", {31'b0, stall}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_valid", {31'b0, result_valid}, 32'd0);
            chk("rst_result", result, 32'd0);
        end else begin
            rel = cyc - op_c0;
            es  = op_active && rel >= 0 && rel < op_lat;
            ev  = op_active && rel == op_lat;
            eb  = op_active && rel >= 1 && rel <= op_lat;
            if (flush) begin
                es = 0;
                ev = 0;
            end
            chk("stall", {31'b0, stall}, {31'b0, es});
            chk("busy", {31'b0, busy}, {31'b0, eb});
            chk("result_valid", {31'b0, result_valid}, {31'b0, ev});
            if (ev) begin
                chk("result", result, op_exp);
                last_result = op_exp;
                cap_val     = result;
                n_valid++;
            end else begin
                chk("result_hold", result, last_result);
            end
            if (flush || (op_active && rel >= op_lat)) op_active = 0;
        end
    end

    task automatic begin_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] fa, input logic [1:0] fb,
                            input logic [31:0] exa, input logic [31:0] mwb);
        logic [31:0] ea, eb;
        ea = (fa == 2'b10) ? exa : (fa == 2'b01) ? mwb : a;
        eb = (fb == 2'b10) ? exa : (fb == 2'b01) ? mwb : b;
        funct3 = f; rs1_val = a; rs2_val = b; forwardA = fa; forwardB = fb;
        ex_mem_alu_out = exa; mem_wb_wdata = mwb; start = 1'b1;
        op_exp = model(f, ea, eb);
        op_lat = latency(f, ea, eb);
        op_c0  = cyc;
        op_active = 1;
    endtask

    // Runs one op to completion; lit is the hand-computed answer
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic [31:0] exa, input logic [31:0] mwb,
                          input logic [31:0] lit, input bit scramble);
        int nv0, lat;
        nv0 = n_valid;
        begin_op(f, a, b, fa, fb, exa, mwb);
        lat = op_lat;
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            if (scramble && i == 3) begin
                ex_mem_alu_out = '0; mem_wb_wdata = '0; rs1_val = '0; rs2_val = '0;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("pulse_count", 32'(n_valid - nv0), 32'd1);
        chk("literal", cap_val, lit);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'b000, 32'hFFFFFFFD, 32'd7,        2'b00, 2'b00, 0, 0, 32'hFFFFFFEB, 0);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 2'b00, 0, 0, 32'hFFFFFFFE, 0);
        run_op(3'b010, 32'hFFFFFFFF, 32'd2,        2'b00, 2'b00, 0, 0, 32'hFFFFFFFF, 0);
        run_op(3'b001, 32'h80000000, 32'h80000000, 2'b11, 2'b00, 0, 0, 32'h40000000, 0);
        run_op(3'b100, 32'hFFFFFFEC, 32'd6,        2'b00, 2'b00, 0, 0, 32'hFFFFFFFD, 0);
        run_op(3'b110, 32'hFFFFFFEC, 32'd6,        2'b00, 2'b00, 0, 0, 32'hFFFFFFFE, 0);
        run_op(3'b100, 32'd7,        32'hFFFFFFFE, 2'b00, 2'b00, 0, 0, 32'hFFFFFFFD, 0);
        run_op(3'b110, 32'd7,        32'hFFFFFFFE, 2'b00, 2'b00, 0, 0, 32'd1,        0);
        run_op(3'b101, 32'd100,      32'd7,        2'b00, 2'b00, 0, 0, 32'd14,       0);
        run_op(3'b111, 32'd100,      32'd7,        2'b00, 2'b00, 0, 0, 32'd2,        0);
        run_op(3'b101, 32'd5,        32'd0,        2'b00, 2'b00, 0, 0, 32'hFFFFFFFF, 0);
        run_op(3'b111, 32'd5,        32'd0,        2'b00, 2'b00, 0, 0, 32'd5,        0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 0, 0, 32'h80000000, 0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 0, 0, 32'd0,        0);
        // forwarded operands, sources cleared mid-op
        run_op(3'b100, 32'd5,        32'd9,        2'b10, 2'b01, 32'd100, 32'd7, 32'd14, 1);

        // flush at BUSY cycle 10
        begin_op(3'b000, 32'd123, 32'd456, 2'b00, 2'b00, 0, 0);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        // start coincident with flush in IDLE is ignored
        funct3 = 3'b000; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        run_op(3'b000, 32'd6, 32'd7, 2'b00, 2'b00, 0, 0, 32'd42, 0);

        // asynchronous reset at BUSY cycle 5
        begin_op(3'b000, 32'd11, 32'd13, 2'b00, 2'b00, 0, 0);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("async_busy", {31'b0, busy}, 32'd0);
        chk("async_stall", {31'b0, stall}, 32'd0);
        chk("async_valid", {31'b0, result_valid}, 32'd0);
        chk("async_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end

        // back-to-back
        run_op(3'b101, 32'd9, 32'd3, 2'b00, 2'b00, 0, 0, 32'd3, 0);
        run_op(3'b000, 32'd3, 32'd3, 2'b00, 2'b00, 0, 0, 32'd9, 0);

        repeat (3) begin @(posedge clk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
